mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single CPU memory port between instruction fetch (IFU) and load/store (LSU).
//  Sits in the CPU top between IFU/LSU and the memory/bus interface.
//  Accepts at most one request at a time, forwards it downstream and routes the response back.
//  Frees the port only after that response returns.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  data width; wmask width is DATA_W/8
//  RR_EN      1   1: round-robin on ties; 0: fixed priority, LSU wins ties
// PORTS
//  clk            in   1        clock, rising edge
//  rstn           in   1        synchronous reset, active-low
//  ifu_req_valid  in   1        IFU fetch request
//  ifu_req_ready  out  1        IFU request accepted this cycle
//  ifu_addr       in   ADDR_W   fetch address
//  ifu_rsp_valid  out  1        fetch data valid (1-cycle pulse)
//  ifu_rdata      out  DATA_W   fetched instruction
//  lsu_req_valid  in   1        LSU request
//  lsu_req_ready  out  1        LSU request accepted this cycle
//  lsu_addr       in   ADDR_W   load/store address
//  lsu_wen        in   1        1=store, 0=load
//  lsu_wdata      in   DATA_W   store data
//  lsu_wmask      in   DATA_W/8 byte enables
//  lsu_rsp_valid  out  1        load data / store ack (1-cycle pulse)
//  lsu_rdata      out  DATA_W   load data (0 for stores)
//  mem_req_valid  out  1        downstream request valid
//  mem_req_ready  in   1        downstream accepts request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  registered request
//  mem_rsp_valid  in   1        downstream response valid; no backpressure
//  mem_rdata      in   DATA_W   downstream read data
//  arb_busy       out  1        state != IDLE
//  arb_err        out  1        sticky: mem_rsp_valid received outside RSP
// BEHAVIOUR
//  Reset (rstn=0 at posedge):
//   - state=IDLE, last_owner=LSU (first tie goes to IFU when RR_EN=1).
//   - arb_err=0; all mem_* request regs=0.
//   - All outputs 0 while in IDLE with no valid requests.
//  FSM IDLE -> REQ -> RSP -> IDLE.
//  IDLE: grant is combinational.
//   - Only one valid: grant it.
//   - Both valid: RR_EN=1 -> non-last_owner; RR_EN=0 -> LSU.
//   - Granted *_req_ready=1 in the same cycle.
//   - Posedge: latch owner, addr, wen, wdata, wmask; go to REQ.
//   - IFU requests are latched with wen=0, wmask=0, wdata=0.
//  REQ: mem_req_valid=1; request fields held stable.
//   - mem_req_ready=1 -> RSP at posedge.
//   - Otherwise stay in REQ (no timeout).
//  RSP: mem_req_valid=0.
//   - mem_rsp_valid=1: owner's rsp_valid=1 in that cycle, combinationally.
//   - Owner's rdata=mem_rdata (0 if store).
//   - Posedge: last_owner<=owner; go to IDLE.
//  *_req_ready=0 in REQ/RSP; requesters keep valid asserted until ready.
//  Throughput: min 3 cycles per transaction; accept@T, mem_req_valid@T+1, rsp no earlier than T+2.
//  Non-owner rsp_valid always 0; rdata outputs are 0 when rsp_valid=0.
//  mem_rsp_valid in IDLE/REQ: ignored, not routed; arb_err<=1 (sticky until reset).
//  Reset mid-transaction: outstanding request dropped; mem_req_valid=0 after that edge.
//   - Any later response is handled per the stray-response rule above.
//  Request held in REQ: input changes on ifu_/lsu_ ports do not affect mem_* outputs.
// TESTING
//  1 IFU only: ifu addr 0x80000000, mem_req_ready=1, rsp rdata=0x00100073 next cycle.
//    -> ifu_rsp_valid pulse with 0x00100073; 3-cycle turnaround.
//  2 Tie, RR_EN=1, both valid continuously. -> grants IFU,LSU,IFU,LSU.
//    Same with RR_EN=0 -> LSU every time.
//  3 LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF; mem_req_ready low 4 cycles.
//    -> mem_* fields stable for all 5 cycles; lsu_rsp_valid with rdata=0.
//  4 mem_rsp_valid pulsed while IDLE. -> no rsp_valid on either port; arb_err=1 until rstn=0.
//  5 rstn=0 while in RSP. -> next cycle IDLE, arb_busy=0, mem_req_valid=0.
//    Late rsp sets arb_err; first post-reset tie goes to IFU.
//  6 LSU request arrives while IFU transaction in REQ.
//    -> lsu_req_ready=0 until IDLE, then granted (RR, last_owner=IFU).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction in flight: IDLE grants, REQ presents the request downstream, RSP routes the reply back.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    // Handshakes: a request transfers in the cycle where valid and ready are both high;
    // requesters hold valid and their fields steady until they see ready.
    // Responses are single-cycle pulses with no backpressure.
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_busy,
    output logic                arb_err,
    output logic [1:0]          arb_state
);

    localparam int MASK_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic              r_err;

    logic              w_idle;
    logic              w_grant_ifu;
    logic              w_grant_lsu;
    logic              w_accept;
    logic              w_rsp_fire;
    logic              w_stray_rsp;
    logic [1:0]        w_next_state;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = w_grant_ifu | w_grant_lsu;
    assign w_rsp_fire  = (r_state == ST_RSP) & mem_rsp_valid;
    assign w_stray_rsp = (r_state != ST_RSP) & mem_rsp_valid;

    // Ties alternate away from the previous owner when round-robin is on, otherwise LSU wins.
    always_comb begin
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        if (w_idle) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (RR_EN && (r_last_owner == OWN_LSU)) begin
                    w_grant_ifu = 1'b1;
                end else begin
                    w_grant_lsu = 1'b1;
                end
            end else begin
                w_grant_ifu = ifu_req_valid;
                w_grant_lsu = lsu_req_valid;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)      w_next_state = ST_REQ;
            ST_REQ:  if (mem_req_ready) w_next_state = ST_RSP;
            ST_RSP:  if (mem_rsp_valid) w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IFU;
            r_last_owner <= OWN_LSU;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_lsu) begin
                r_owner <= OWN_LSU;
                r_addr  <= lsu_addr;
                r_wen   <= lsu_wen;
                r_wdata <= lsu_wdata;
                r_wmask <= lsu_wmask;
            end else if (w_grant_ifu) begin
                r_owner <= OWN_IFU;
                r_addr  <= ifu_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
            end
            // Clearing the request on completion keeps every mem_* output at zero while idle.
            if (w_rsp_fire) begin
                r_last_owner <= r_owner;
                r_addr       <= '0;
                r_wen        <= 1'b0;
                r_wdata      <= '0;
                r_wmask      <= '0;
            end
            if (w_stray_rsp) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ifu_req_ready = w_grant_ifu;
    assign lsu_req_ready = w_grant_lsu;

    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    assign ifu_rsp_valid = w_rsp_fire & (r_owner == OWN_IFU);
    assign lsu_rsp_valid = w_rsp_fire & (r_owner == OWN_LSU);
    assign ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
    // Stores acknowledge with zero data regardless of what the bus returns.
    assign lsu_rdata     = (lsu_rsp_valid && !r_wen) ? mem_rdata : '0;

    assign arb_busy  = (r_state != ST_IDLE);
    assign arb_err   = r_err;
    assign arb_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance is fully checked, a
// fixed-priority instance shares its inputs and is checked on tie grants.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk;
  logic          rstn;
  logic          ifu_req_valid;
  logic [AW-1:0] ifu_addr;
  logic          lsu_req_valid;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [DW-1:0] lsu_wdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rdata;

  logic          ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid;
  logic [DW-1:0] ifu_rdata, lsu_rdata, mem_wdata;
  logic          mem_req_valid, mem_wen, arb_busy, arb_err;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wmask;
  logic [1:0]    arb_state;

  logic          fp_ifu_req_ready, fp_ifu_rsp_valid, fp_lsu_req_ready, fp_lsu_rsp_valid;
  logic [DW-1:0] fp_ifu_rdata, fp_lsu_rdata, fp_mem_wdata;
  logic          fp_mem_req_valid, fp_mem_wen, fp_arb_busy, fp_arb_err;
  logic [AW-1:0] fp_mem_addr;
  logic [MW-1:0] fp_mem_wmask;
  logic [1:0]    fp_arb_state;

  int n_checks = 0;
  int n_errors = 0;
  // {port (1 = LSU), data}
  logic [DW:0] exp_q[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .arb_busy(arb_busy), .arb_err(arb_err), .arb_state(arb_state)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(fp_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(fp_ifu_rsp_valid), .ifu_rdata(fp_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(fp_lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(fp_lsu_rsp_valid), .lsu_rdata(fp_lsu_rdata),
    .mem_req_valid(fp_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(fp_mem_addr),
    .mem_wen(fp_mem_wen), .mem_wdata(fp_mem_wdata), .mem_wmask(fp_mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .arb_busy(fp_arb_busy), .arb_err(fp_arb_err), .arb_state(fp_arb_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
  endtask

  // Called just after the accepting edge; walks the transaction through REQ and RSP.
  task automatic serve(input int stall, input int delay, input logic [DW-1:0] rdata,
                       input logic [AW-1:0] e_addr, input logic e_wen,
                       input logic [DW-1:0] e_wdata, input logic [MW-1:0] e_wmask,
                       input bit scramble);
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready = (i == stall);
      if (scramble) begin
        ifu_addr  = $urandom;
        lsu_addr  = $urandom;
        lsu_wdata = $urandom;
        lsu_wmask = MW'($urandom_range(0, 15));
        lsu_wen   = 1'($urandom_range(0, 1));
      end
      #1;
      check("req_valid", mem_req_valid, 1'b1);
      check("req_addr", mem_addr, e_addr);
      check("req_wen", mem_wen, e_wen);
      check("req_wdata", mem_wdata, e_wdata);
      check("req_wmask", mem_wmask, e_wmask);
      check("req_busy", arb_busy, 1'b1);
      check("req_readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
      step();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      #1;
      check("rsp_wait_valid", mem_req_valid, 1'b0);
      check("rsp_wait_busy", arb_busy, 1'b1);
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    #1;
    check("rsp_req_valid", mem_req_valid, 1'b0);
    check("rsp_readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
  endtask

  // scoreboard: every response pulse pops one expected entry
  always @(negedge clk) begin
    if (rstn) begin
      if (ifu_rsp_valid || lsu_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("rsp_onehot", ifu_rsp_valid & lsu_rsp_valid, 1'b0);
          check("rsp_port", lsu_rsp_valid, e[DW]);
          check("rsp_data", lsu_rsp_valid ? lsu_rdata : ifu_rdata, e[DW-1:0]);
        end
      end
      if (!ifu_rsp_valid) check("ifu_rdata_idle", ifu_rdata, '0);
      if (!lsu_rsp_valid) check("lsu_rdata_idle", lsu_rdata, '0);
    end
  end

  initial begin
    rstn = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    do_reset();
    #1;
    check("rst_busy", arb_busy, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_addr", mem_addr, '0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_err", arb_err, 1'b0);
    check("rst_readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
    check("rst_state", arb_state, 2'd0);

    // 1: lone IFU fetch, store-side fields must not leak into the request
    lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF; lsu_wen = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    #1;
    check("t1_ifu_ready", ifu_req_ready, 1'b1);
    check("t1_lsu_ready", lsu_req_ready, 1'b0);
    exp_q.push_back({1'b0, 32'h0010_0073});
    step();
    idle_inputs();
    serve(0, 0, 32'h0010_0073, 32'h8000_0000, 1'b0, '0, '0, 1'b0);
    #1;
    check("t1_done_busy", arb_busy, 1'b0);
    check("t1_done_addr", mem_addr, '0);

    // 2: continuous tie, RR alternates IFU/LSU, fixed priority always LSU
    do_reset();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic want_lsu;
      logic [AW-1:0] ia, la;
      logic [DW-1:0] wd;
      want_lsu = (i % 2) == 1;
      ia = 32'h8000_0000 + 32'(4 * i);
      la = 32'h8000_2000 + 32'(4 * i);
      wd = 32'hA5A5_0000 + 32'(i);
      ifu_addr = ia; lsu_addr = la; lsu_wen = 1'b0; lsu_wdata = wd; lsu_wmask = 4'hF;
      #1;
      check("t2_rr_ifu_ready", ifu_req_ready, !want_lsu);
      check("t2_rr_lsu_ready", lsu_req_ready, want_lsu);
      check("t2_fp_lsu_ready", fp_lsu_req_ready, 1'b1);
      check("t2_fp_ifu_ready", fp_ifu_req_ready, 1'b0);
      exp_q.push_back({want_lsu, 32'h0000_1000 + 32'(i)});
      step();
      if (want_lsu) serve(i % 2, 0, 32'h0000_1000 + 32'(i), la, 1'b0, wd, 4'hF, 1'b0);
      else          serve(i % 2, 0, 32'h0000_1000 + 32'(i), ia, 1'b0, '0, '0, 1'b0);
    end
    idle_inputs();

    // 3: stalled store, inputs churn while the request is held
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    #1;
    check("t3_lsu_ready", lsu_req_ready, 1'b1);
    exp_q.push_back({1'b1, 32'h0});
    step();
    idle_inputs();
    serve(4, 1, 32'h1234_5678, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1);

    // 4: stray response in IDLE sets the sticky error, later traffic leaves it set
    mem_rsp_valid = 1'b1; mem_rdata = 32'hAAAA_5555;
    #1;
    check("t4_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    step();
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    check("t4_err_set", arb_err, 1'b1);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    exp_q.push_back({1'b0, 32'h0000_0013});
    step();
    idle_inputs();
    serve(1, 1, 32'h0000_0013, 32'h8000_0040, 1'b0, '0, '0, 1'b0);
    check("t4_err_sticky", arb_err, 1'b1);
    do_reset();
    check("t4_err_cleared", arb_err, 1'b0);

    // 4b: stray response while in REQ
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
    lsu_wdata = 32'h0; lsu_wmask = 4'hF;
    step();
    idle_inputs();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    check("t4b_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    step();
    mem_rsp_valid = 1'b0;
    check("t4b_err_set", arb_err, 1'b1);
    check("t4b_still_req", mem_req_valid, 1'b1);
    exp_q.push_back({1'b1, 32'h0BAD_F00D});
    serve(0, 0, 32'h0BAD_F00D, 32'h8000_3000, 1'b0, 32'h0, 4'hF, 1'b0);

    // 5: reset during RSP drops the transaction
    do_reset();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; lsu_wen = 1'b0;
    step();
    idle_inputs();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("t5_in_rsp", arb_state, 2'd2);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("t5_busy", arb_busy, 1'b0);
    check("t5_req_valid", mem_req_valid, 1'b0);
    check("t5_err_clear", arb_err, 1'b0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    check("t5_late_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    step();
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    check("t5_late_err", arb_err, 1'b1);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_5000;
    #1;
    check("t5_tie_ifu", ifu_req_ready, 1'b1);
    check("t5_tie_lsu", lsu_req_ready, 1'b0);
    exp_q.push_back({1'b0, 32'h0000_0093});
    step();
    idle_inputs();
    serve(0, 0, 32'h0000_0093, 32'h8000_0100, 1'b0, '0, '0, 1'b0);

    // 6: LSU arrives while IFU is in REQ, waits, then is granted
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    exp_q.push_back({1'b0, 32'h0000_0297});
    step();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_6000; lsu_wen = 1'b0;
    lsu_wdata = 32'h0000_0001; lsu_wmask = 4'h3;
    serve(2, 1, 32'h0000_0297, 32'h8000_0200, 1'b0, '0, '0, 1'b0);
    #1;
    check("t6_lsu_ready", lsu_req_ready, 1'b1);
    check("t6_ifu_ready", ifu_req_ready, 1'b0);
    exp_q.push_back({1'b1, 32'hCAFE_0006});
    step();
    idle_inputs();
    serve(0, 2, 32'hCAFE_0006, 32'h8000_6000, 1'b0, 32'h0000_0001, 4'h3, 1'b0);

    step();
    step();
    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
